// File: rtl/elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_scan_ctrl
//   Single-car elevator controller for NUM_FLOORS floors. The controller
//   latches floor calls and serves them SCAN-style: it keeps travelling in the
//   current direction while requests lie ahead, and reverses only when nothing
//   is left ahead. One shared timer counts the floor-to-floor travel time and
//   the door dwell time. The door-close button shortens the dwell.
//
// Parameters
//   NUM_FLOORS     number of floors (>= 2), floor 0 is home
//   TRAVEL_CYCLES  clock cycles to move one floor (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open without close_req (>= 1)
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   rst            asynchronous active-high reset, abandons all requests
//   call           per-floor request, sampled every cycle (pulse or level)
//   close_req      door-close button, sampled every cycle
//   pending        latched outstanding requests (floor LED drive)
//   current_floor  floor the car is at or last departed
//   up             car moving upward
//   down           car moving downward
//   door_open      door open at current_floor
// -----------------------------------------------------------------------------
module elevator_scan_ctrl #(
   parameter int unsigned NUM_FLOORS    = 6,
   parameter int unsigned TRAVEL_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES   = 4,
   localparam int unsigned FLOOR_W      = $clog2(NUM_FLOORS),
   localparam int unsigned MAX_CYC      = (TRAVEL_CYCLES > DOOR_CYCLES) ?
                                          TRAVEL_CYCLES : DOOR_CYCLES,
   localparam int unsigned CNT_W        = $clog2(MAX_CYC + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] call,
   input  logic                  close_req,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  up,
   output logic                  down,
   output logic                  door_open
);

   typedef enum logic [1:0] {
      IDLE,
      MOVING,
      DOOR_OPEN
   } state_t;

   typedef enum logic {
      UP,
      DN
   } dir_t;

   localparam logic [CNT_W-1:0] TRAVEL_RELOAD = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_RELOAD   = CNT_W'(DOOR_CYCLES - 1);

   state_t                  state;
   dir_t                    dir;
   logic [CNT_W-1:0]        timer;

   // Decision helpers, all derived from req = pending | call
   logic [NUM_FLOORS-1:0]   req;
   logic [NUM_FLOORS-1:0]   clr;
   logic                    here_req;    // request at current_floor
   logic                    call_here;   // fresh call at current_floor
   logic                    above;       // any request above current_floor
   logic                    below;       // any request below current_floor
   logic                    at_next;     // request at the floor being approached
   logic                    ahead_next;  // request beyond the floor being approached
   logic                    arriving;    // this cycle completes a floor step

   assign req      = pending | call;
   assign arriving = (state == MOVING) && (timer == '0);

   // Floor comparisons are done in 32-bit arithmetic so that the neighbour
   // floor never wraps around at floor 0 or at the top floor.
   always_comb begin
      here_req   = 1'b0;
      call_here  = 1'b0;
      above      = 1'b0;
      below      = 1'b0;
      at_next    = 1'b0;
      ahead_next = 1'b0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (i == 32'(current_floor)) begin
            here_req  = here_req  | req[i];
            call_here = call_here | call[i];
         end
         if (i > 32'(current_floor)) begin
            above = above | req[i];
         end
         if (i < 32'(current_floor)) begin
            below = below | req[i];
         end
         if (dir == UP) begin
            if (i == 32'(current_floor) + 1) begin
               at_next = at_next | req[i];
            end
            if (i > 32'(current_floor) + 1) begin
               ahead_next = ahead_next | req[i];
            end
         end else begin
            if (i + 1 == 32'(current_floor)) begin
               at_next = at_next | req[i];
            end
            if (i + 1 < 32'(current_floor)) begin
               ahead_next = ahead_next | req[i];
            end
         end
      end
   end

   // While stopped, the current floor is served and never latched. On an
   // arrival that opens the door, the arrival floor is cleared on the same
   // edge so the LED goes dark together with door_open rising.
   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
         if (state != MOVING) begin
            clr[i] = (i == 32'(current_floor));
         end else if (arriving && at_next) begin
            if (dir == UP) begin
               clr[i] = (i == 32'(current_floor) + 1);
            end else begin
               clr[i] = (i + 1 == 32'(current_floor));
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         dir           <= UP;
         current_floor <= '0;
         pending       <= '0;
         timer         <= '0;
         up            <= 1'b0;
         down          <= 1'b0;
         door_open     <= 1'b0;
      end else begin
         pending <= (pending | call) & ~clr;

         case (state)
            IDLE: begin
               if (here_req) begin
                  state     <= DOOR_OPEN;
                  timer     <= DOOR_RELOAD;
                  door_open <= 1'b1;
               end else if (((dir == UP) && above) || ((dir == DN) && below)) begin
                  state <= MOVING;
                  timer <= TRAVEL_RELOAD;
                  up    <= (dir == UP);
                  down  <= (dir == DN);
               end else if (above) begin
                  dir   <= UP;
                  state <= MOVING;
                  timer <= TRAVEL_RELOAD;
                  up    <= 1'b1;
                  down  <= 1'b0;
               end else if (below) begin
                  dir   <= DN;
                  state <= MOVING;
                  timer <= TRAVEL_RELOAD;
                  up    <= 1'b0;
                  down  <= 1'b1;
               end
            end

            MOVING: begin
               if (timer != '0) begin
                  timer <= timer - CNT_W'(1);
               end else begin
                  if (dir == UP) begin
                     current_floor <= current_floor + FLOOR_W'(1);
                  end else begin
                     current_floor <= current_floor - FLOOR_W'(1);
                  end
                  if (at_next) begin
                     state     <= DOOR_OPEN;
                     timer     <= DOOR_RELOAD;
                     up        <= 1'b0;
                     down      <= 1'b0;
                     door_open <= 1'b1;
                  end else if (ahead_next) begin
                     timer <= TRAVEL_RELOAD;
                  end else begin
                     state <= IDLE;
                     up    <= 1'b0;
                     down  <= 1'b0;
                  end
               end
            end

            DOOR_OPEN: begin
               // A fresh call for this floor holds the door even against close_req
               if (call_here) begin
                  timer <= DOOR_RELOAD;
               end else if (close_req || (timer == '0)) begin
                  state     <= IDLE;
                  door_open <= 1'b0;
               end else begin
                  timer <= timer - CNT_W'(1);
               end
            end

            default: begin
               state     <= IDLE;
               timer     <= '0;
               up        <= 1'b0;
               down      <= 1'b0;
               door_open <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_scan_ctrl
//   Self-checking bench for elevator_scan_ctrl with 6 floors, 4-cycle travel
//   and 4-cycle door dwell. A table of {inputs, cycles, expected outputs}
//   records walks the car through SCAN service, door handling and direction
//   reversal; hand-written sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_elevator_scan_ctrl;

   typedef struct packed {
      logic [5:0] pend;
      logic [2:0] floor;
      logic       up;
      logic       down;
      logic       door;
   } out_t;

   // Inputs are presented for the first edge only, then held at zero for the
   // remaining n-1 edges; outputs are compared after the n-th edge.
   typedef struct packed {
      logic [5:0] call;
      logic       close;
      logic [7:0] n;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [5:0] call = '0;
   logic       close_req = 1'b0;
   logic [5:0] pending;
   logic [2:0] current_floor;
   logic       up;
   logic       down;
   logic       door_open;

   int   compared   = 0;
   int   mismatched = 0;
   vec_t tbl[$];
   out_t exp_q[$];

   elevator_scan_ctrl #(
      .NUM_FLOORS   (6),
      .TRAVEL_CYCLES(4),
      .DOOR_CYCLES  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .call         (call),
      .close_req    (close_req),
      .pending      (pending),
      .current_floor(current_floor),
      .up           (up),
      .down         (down),
      .door_open    (door_open)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic [5:0] c, input logic cl, input int n,
                               input logic [5:0] p, input logic [2:0] f,
                               input logic u, input logic d, input logic o);
      vec_t v;
      v.call       = c;
      v.close      = cl;
      v.n          = 8'(n);
      v.exp.pend   = p;
      v.exp.floor  = f;
      v.exp.up     = u;
      v.exp.down   = d;
      v.exp.door   = o;
      tbl.push_back(v);
   endfunction

   task automatic check(input string name);
      out_t e;
      out_t a;
      a = {pending, current_floor, up, down, door_open};
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL %s: scoreboard empty, got pend=%b floor=%0d", name, pending, current_floor);
      end else begin
         e = exp_q.pop_front();
         if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got pend=%b floor=%0d up=%b down=%b door=%b, want pend=%b floor=%0d up=%b down=%b door=%b",
                     name, a.pend, a.floor, a.up, a.down, a.door,
                     e.pend, e.floor, e.up, e.down, e.door);
         end
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      call      = v.call;
      close_req = v.close;
      exp_q.push_back(v.exp);
      for (int k = 0; k < int'(v.n); k++) begin
         @(posedge clk);
         #1;
         call      = '0;
         close_req = 1'b0;
      end
      check($sformatf("vec%0d", idx));
   endtask

   task automatic expect_now(input string name, input out_t e);
      exp_q.push_back(e);
      check(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running, want finished");
      $fatal(1);
   end

   initial begin
      //   call       cl n   pending    fl  up dn door
      // call[3] from floor 0: one floor every 4 cycles, door at 3
      add(6'b001000, 0, 1,  6'b001000, 0, 1, 0, 0);
      add(6'b000000, 0, 3,  6'b001000, 0, 1, 0, 0);
      add(6'b000000, 0, 1,  6'b001000, 1, 1, 0, 0);
      add(6'b000000, 0, 4,  6'b001000, 2, 1, 0, 0);
      add(6'b000000, 0, 3,  6'b001000, 2, 1, 0, 0);
      add(6'b000000, 0, 1,  6'b000000, 3, 0, 0, 1);
      add(6'b000000, 0, 3,  6'b000000, 3, 0, 0, 1);
      add(6'b000000, 0, 1,  6'b000000, 3, 0, 0, 0);
      // floor 3 heading up with calls {1,5}: 5 first, then reverse to 1
      add(6'b100010, 0, 1,  6'b100010, 3, 1, 0, 0);
      add(6'b000000, 0, 4,  6'b100010, 4, 1, 0, 0);
      add(6'b000000, 0, 3,  6'b100010, 4, 1, 0, 0);
      add(6'b000000, 0, 1,  6'b000010, 5, 0, 0, 1);
      add(6'b000000, 0, 4,  6'b000010, 5, 0, 0, 0);
      add(6'b000000, 0, 1,  6'b000010, 5, 0, 1, 0);
      add(6'b000000, 0, 8,  6'b000010, 3, 0, 1, 0);
      add(6'b000000, 0, 8,  6'b000000, 1, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 1, 0, 0, 0);
      // door at 2: close_req together with call[2] keeps it open, timer reloads
      add(6'b000100, 0, 1,  6'b000100, 1, 1, 0, 0);
      add(6'b000000, 0, 4,  6'b000000, 2, 0, 0, 1);
      add(6'b000100, 1, 1,  6'b000000, 2, 0, 0, 1);
      add(6'b000000, 0, 3,  6'b000000, 2, 0, 0, 1);
      add(6'b000000, 0, 1,  6'b000000, 2, 0, 0, 0);
      add(6'b000100, 0, 1,  6'b000000, 2, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 2, 0, 0, 0);
      // down to 1, then up toward 4 with an intermediate call for 2
      add(6'b000010, 0, 1,  6'b000010, 2, 0, 1, 0);
      add(6'b000000, 0, 4,  6'b000000, 1, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 1, 0, 0, 0);
      add(6'b010000, 0, 1,  6'b010000, 1, 1, 0, 0);
      add(6'b000100, 0, 1,  6'b010100, 1, 1, 0, 0);
      add(6'b000000, 0, 3,  6'b010000, 2, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b010000, 2, 0, 0, 0);
      add(6'b000000, 0, 1,  6'b010000, 2, 1, 0, 0);
      add(6'b000000, 0, 8,  6'b000000, 4, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 4, 0, 0, 0);
      // home, then call[0] at 0 never latches; call[0] while leaving does
      add(6'b000001, 0, 1,  6'b000001, 4, 0, 1, 0);
      add(6'b000000, 0, 16, 6'b000000, 0, 0, 0, 1);
      add(6'b000000, 0, 4,  6'b000000, 0, 0, 0, 0);
      add(6'b000001, 0, 1,  6'b000000, 0, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 0, 0, 0, 0);
      add(6'b000100, 0, 1,  6'b000100, 0, 1, 0, 0);
      add(6'b000001, 0, 1,  6'b000101, 0, 1, 0, 0);
      add(6'b000000, 0, 7,  6'b000001, 2, 0, 0, 1);
      add(6'b000000, 0, 4,  6'b000001, 2, 0, 0, 0);
      add(6'b000000, 0, 1,  6'b000001, 2, 0, 1, 0);
      add(6'b000000, 0, 8,  6'b000000, 0, 0, 0, 1);
      add(6'b000000, 1, 1,  6'b000000, 0, 0, 0, 0);
      // head for 5 and get interrupted by reset one floor up
      add(6'b100000, 0, 5,  6'b100000, 1, 1, 0, 0);

      // power-on reset, asserted between clock edges
      #1 rst = 1'b1;
      #2 expect_now("reset_async", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b0});
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1 expect_now("reset_idle", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b0});

      for (int i = 0; i < tbl.size(); i++) begin
         apply(i, tbl[i]);
      end

      // reset mid-travel: outputs clear without waiting for a clock edge
      #2 rst = 1'b1;
      #1 expect_now("reset_mid_travel", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b0});
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 expect_now("reset_abandons", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b0});

      // reset with the door open
      call = 6'b000001;
      @(posedge clk);
      #1 call = '0;
      expect_now("door_before_reset", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b1});
      #2 rst = 1'b1;
      #1 expect_now("reset_door_open", '{pend:6'b0, floor:3'd0, up:1'b0, down:1'b0, door:1'b0});
      #2 rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
